// File: rtl/rans_encoder_interleaved_if.sv
// Symbol-in / word-out handshake bundle for the interleaved rANS encoder core.
interface rans_encoder_interleaved_if #(
  parameter int RESOLUTION = 10,
  parameter int OUT_WIDTH  = 8,
  parameter int N_LANES    = 4,
  parameter int LW         = (N_LANES > 1) ? $clog2(N_LANES) : 1
);
  logic                  in_valid;
  logic                  in_ready;
  logic [RESOLUTION:0]   in_freq;
  logic [RESOLUTION-1:0] in_cum_freq;
  logic                  in_flush;
  logic                  out_valid;
  logic                  out_ready;
  logic [OUT_WIDTH-1:0]  out_data;
  logic [LW-1:0]         out_lane;
  logic                  out_last;
  logic                  err;

  modport slave (
    input  in_valid, in_freq, in_cum_freq, in_flush, out_ready,
    output in_ready, out_valid, out_data, out_lane, out_last, err
  );

  modport master (
    output in_valid, in_freq, in_cum_freq, in_flush, out_ready,
    input  in_ready, out_valid, out_data, out_lane, out_last, err
  );
endinterface

// File: rtl/rans_encoder_interleaved.sv
// N-lane interleaved rANS encoder: round-robin lanes, renormalise, restoring divide, flush dump.
// Optional macro RANS_ERR_CHECK_EN adds a sticky err flag for f==0 or c+f > 2^RESOLUTION.
module rans_encoder_interleaved #(
  parameter int RESOLUTION  = 10,
  parameter int STATE_WIDTH = 32,
  parameter int OUT_WIDTH   = 8,
  parameter int N_LANES     = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  rans_encoder_interleaved_if.slave    bus
);
  localparam int LW    = (N_LANES > 1) ? $clog2(N_LANES) : 1;
  localparam int WORDS = STATE_WIDTH / OUT_WIDTH;
  localparam int WCW   = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int CW    = (STATE_WIDTH > 1) ? $clog2(STATE_WIDTH) : 1;

  localparam logic [STATE_WIDTH-1:0] L_INIT    = STATE_WIDTH'(1) << (STATE_WIDTH - OUT_WIDTH);
  localparam logic [LW-1:0]          LAST_LANE = LW'(N_LANES - 1);
  localparam logic [WCW-1:0]         LAST_WORD = WCW'(WORDS - 1);
  localparam logic [CW-1:0]          DIV_LAST  = CW'(STATE_WIDTH - 1);

  // state | meaning: IDLE accept beat | RENORM emit low words | DIV x/f | UPD write lane | FLUSH dump lanes
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RENORM = 3'd1;
  localparam logic [2:0] S_DIV    = 3'd2;
  localparam logic [2:0] S_UPD    = 3'd3;
  localparam logic [2:0] S_FLUSH  = 3'd4;

  logic [2:0]             state_q, state_d;
  logic [STATE_WIDTH-1:0] lane_q [N_LANES];
  logic [STATE_WIDTH-1:0] lane_d [N_LANES];
  logic [LW-1:0]          ptr_q, ptr_d;
  logic [STATE_WIDTH-1:0] x_q, x_d;
  logic [RESOLUTION:0]    f_q, f_d;
  logic [RESOLUTION-1:0]  c_q, c_d;
  logic [RESOLUTION:0]    r_q, r_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [LW-1:0]          fl_lane_q, fl_lane_d;
  logic [WCW-1:0]         wcnt_q, wcnt_d;
  logic                   in_ready_q, in_ready_d;

  logic                   hs;
  logic                   x_ge;
  logic [STATE_WIDTH:0]   x_max;
  logic [RESOLUTION+1:0]  rem_sh;
  logic                   out_valid_w;

  assign hs     = bus.in_valid & in_ready_q;
  assign x_max  = {f_q, {(STATE_WIDTH-RESOLUTION){1'b0}}};
  assign x_ge   = {1'b0, x_q} >= x_max;
  assign rem_sh = {r_q, x_q[STATE_WIDTH-1]};

`ifdef RANS_ERR_CHECK_EN
  localparam logic [RESOLUTION+1:0] M_TOT = (RESOLUTION+2)'(1) << RESOLUTION;
  logic                  err_q, err_d;
  logic [RESOLUTION+1:0] sum_fc;
  logic                  illegal;
  assign sum_fc  = {1'b0, bus.in_freq} + {2'b00, bus.in_cum_freq};
  assign illegal = (bus.in_freq == '0) || (sum_fc > M_TOT);
  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    lane_d     = lane_q;
    ptr_d      = ptr_q;
    x_d        = x_q;
    f_d        = f_q;
    c_d        = c_q;
    r_d        = r_q;
    cnt_d      = cnt_q;
    fl_lane_d  = fl_lane_q;
    wcnt_d     = wcnt_q;
    in_ready_d = 1'b0;
`ifdef RANS_ERR_CHECK_EN
    err_d      = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        in_ready_d = ~hs;
        if (hs) begin
          if (bus.in_flush) begin
            state_d   = S_FLUSH;
            fl_lane_d = LAST_LANE;
            wcnt_d    = LAST_WORD;
            x_d       = lane_q[LAST_LANE];
          end
`ifdef RANS_ERR_CHECK_EN
          else if (illegal) begin
            err_d = 1'b1;
          end
`endif
          else begin
            state_d = S_RENORM;
            f_d     = bus.in_freq;
            c_d     = bus.in_cum_freq;
            x_d     = lane_q[ptr_q];
          end
        end
      end
      S_RENORM: begin
        if (x_ge) begin
          if (bus.out_ready) x_d = x_q >> OUT_WIDTH;
        end else begin
          state_d = S_DIV;
          r_d     = '0;
          cnt_d   = DIV_LAST;
        end
      end
      S_DIV: begin
        // quotient bits shift into x from the right as dividend bits leave on the left
        if (rem_sh >= {1'b0, f_q}) begin
          r_d = (RESOLUTION+1)'(rem_sh - {1'b0, f_q});
          x_d = {x_q[STATE_WIDTH-2:0], 1'b1};
        end else begin
          r_d = rem_sh[RESOLUTION:0];
          x_d = {x_q[STATE_WIDTH-2:0], 1'b0};
        end
        if (cnt_q == '0) state_d = S_UPD;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_UPD: begin
        lane_d[ptr_q] = (x_q << RESOLUTION) + STATE_WIDTH'(r_q) + STATE_WIDTH'(c_q);
        ptr_d         = (ptr_q == LAST_LANE) ? '0 : ptr_q + 1'b1;
        state_d       = S_IDLE;
      end
      S_FLUSH: begin
        if (bus.out_ready) begin
          if (wcnt_q == '0) begin
            if (fl_lane_q == '0) begin
              for (int i = 0; i < N_LANES; i++) lane_d[i] = L_INIT;
              ptr_d   = '0;
              state_d = S_IDLE;
            end else begin
              fl_lane_d = fl_lane_q - 1'b1;
              x_d       = lane_q[fl_lane_q - 1'b1];
              wcnt_d    = LAST_WORD;
            end
          end else begin
            x_d    = x_q >> OUT_WIDTH;
            wcnt_d = wcnt_q - 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      for (int i = 0; i < N_LANES; i++) lane_q[i] <= L_INIT;
      ptr_q      <= '0;
      x_q        <= '0;
      f_q        <= '0;
      c_q        <= '0;
      r_q        <= '0;
      cnt_q      <= '0;
      fl_lane_q  <= '0;
      wcnt_q     <= '0;
      in_ready_q <= 1'b0;
`ifdef RANS_ERR_CHECK_EN
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      lane_q     <= lane_d;
      ptr_q      <= ptr_d;
      x_q        <= x_d;
      f_q        <= f_d;
      c_q        <= c_d;
      r_q        <= r_d;
      cnt_q      <= cnt_d;
      fl_lane_q  <= fl_lane_d;
      wcnt_q     <= wcnt_d;
      in_ready_q <= in_ready_d;
`ifdef RANS_ERR_CHECK_EN
      err_q      <= err_d;
`endif
    end
  end

  assign out_valid_w   = (state_q == S_FLUSH) | ((state_q == S_RENORM) & x_ge);
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_w;
  assign bus.out_data  = out_valid_w ? x_q[OUT_WIDTH-1:0] : '0;
  assign bus.out_lane  = (state_q == S_FLUSH) ? fl_lane_q : (out_valid_w ? ptr_q : '0);
  assign bus.out_last  = (state_q == S_FLUSH) && (fl_lane_q == '0) && (wcnt_q == '0);
endmodule

// File: tb/tb_rans_encoder_interleaved.sv
// Directed bench for rans_encoder_interleaved (RESOLUTION=10, STATE_WIDTH=32, OUT_WIDTH=8, N_LANES=4).
module tb_rans_encoder_interleaved;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  rans_encoder_interleaved_if #(.RESOLUTION(10), .OUT_WIDTH(8), .N_LANES(4)) bus ();

  rans_encoder_interleaved #(
    .RESOLUTION(10), .STATE_WIDTH(32), .OUT_WIDTH(8), .N_LANES(4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int tests_run = 0;
  int tests_failed = 0;

  logic [7:0] q_data [$];
  logic [1:0] q_lane [$];
  logic       q_last [$];

  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      q_data.push_back(bus.out_data);
      q_lane.push_back(bus.out_lane);
      q_last.push_back(bus.out_last);
    end
  end

  typedef logic [31:0] st_t [4];
  localparam logic [31:0] LV = 32'h0100_0000;

  // expected flush word idx packed as {last, lane, data}; lanes dumped 3..0, low byte first
  function automatic logic [10:0] exp_word(input st_t st, input int idx);
    int ln;
    int k;
    ln = 3 - idx / 4;
    k  = idx % 4;
    return {(idx == 15), 2'(ln), 8'(st[ln] >> (8 * k))};
  endfunction

  task automatic clear_q();
    q_data.delete();
    q_lane.delete();
    q_last.delete();
  endtask

  task automatic send_beat(input logic [10:0] f, input logic [9:0] c, input logic fl,
                           output int hs_cyc, output bit ok);
    ok = 1'b0;
    hs_cyc = 0;
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.in_freq = f;
    bus.in_cum_freq = c;
    bus.in_flush = fl;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.in_ready === 1'b1) begin
        @(posedge clk); #1;
        hs_cyc = cyc;
        ok = 1'b1;
        break;
      end
    end
    bus.in_valid = 1'b0;
    bus.in_flush = 1'b0;
  endtask

  task automatic wait_ready(output int rdy_cyc, output bit ok);
    ok = 1'b0;
    rdy_cyc = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.in_ready === 1'b1) begin
        rdy_cyc = cyc;
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_flush(output bit ok);
    int  h, r;
    bit  ok1, ok2;
    clear_q();
    send_beat(11'd0, 10'd0, 1'b1, h, ok1);
    wait_ready(r, ok2);
    ok = ok1 & ok2;
  endtask

  task automatic encode(input logic [10:0] f, input logic [9:0] c, output int lat, output bit ok);
    int  h, r;
    bit  ok1, ok2;
    send_beat(f, c, 1'b0, h, ok1);
    wait_ready(r, ok2);
    ok = ok1 & ok2;
    lat = r - h;
  endtask

  task automatic test_reset();
    @(negedge clk);
    tests_run++;
    if ({bus.in_ready, bus.out_valid, bus.out_last, bus.err} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got %b required 0000", {bus.in_ready, bus.out_valid, bus.out_last, bus.err});
    end
    tests_run++;
    if ({bus.out_data, bus.out_lane} !== 10'h000) begin
      tests_failed++;
      $display("FAIL reset_data: got %h required 000", {bus.out_data, bus.out_lane});
    end
    rst_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if (bus.in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_in_ready_rise: got %b required 1", bus.in_ready);
    end
  endtask

  task automatic test_flush_after_reset();
    bit   ok;
    st_t  st;
    st = '{LV, LV, LV, LV};
    do_flush(ok);
    tests_run++;
    if (!ok || q_data.size() != 16) begin
      tests_failed++;
      $display("FAIL flush_reset_count: got %0d words (ok=%0d) required 16", q_data.size(), ok);
    end
    for (int i = 0; i < 16 && i < q_data.size(); i++) begin
      tests_run++;
      if ({q_last[i], q_lane[i], q_data[i]} !== exp_word(st, i)) begin
        tests_failed++;
        $display("FAIL flush_reset_word%0d: got %h required %h", i, {q_last[i], q_lane[i], q_data[i]}, exp_word(st, i));
      end
    end
  endtask

  task automatic test_single_symbol();
    bit  ok;
    int  lat;
    st_t st;
    clear_q();
    encode(11'd512, 10'd0, lat, ok);
    tests_run++;
    if (!ok || lat != 35) begin
      tests_failed++;
      $display("FAIL single_latency: got %0d (ok=%0d) required 35", lat, ok);
    end
    tests_run++;
    if (q_data.size() != 0) begin
      tests_failed++;
      $display("FAIL single_no_output: got %0d words required 0", q_data.size());
    end
    st = '{32'h0200_0000, LV, LV, LV};
    do_flush(ok);
    tests_run++;
    if (!ok || q_data.size() != 16) begin
      tests_failed++;
      $display("FAIL single_flush_count: got %0d required 16", q_data.size());
    end
    for (int i = 0; i < 16 && i < q_data.size(); i++) begin
      tests_run++;
      if ({q_last[i], q_lane[i], q_data[i]} !== exp_word(st, i)) begin
        tests_failed++;
        $display("FAIL single_flush_word%0d: got %h required %h", i, {q_last[i], q_lane[i], q_data[i]}, exp_word(st, i));
      end
    end
  endtask

  task automatic test_renorm();
    bit  ok;
    int  lat;
    st_t st;
    clear_q();
    encode(11'd1, 10'd5, lat, ok);
    tests_run++;
    if (!ok || lat != 36) begin
      tests_failed++;
      $display("FAIL renorm_latency: got %0d (ok=%0d) required 36", lat, ok);
    end
    tests_run++;
    if (q_data.size() != 1 || {q_last[0], q_lane[0], q_data[0]} !== 11'h000) begin
      tests_failed++;
      $display("FAIL renorm_word: got %0d words, first %h required 1 word 000", q_data.size(),
               (q_data.size() > 0) ? {q_last[0], q_lane[0], q_data[0]} : 11'h7ff);
    end
    st = '{32'h0400_0005, LV, LV, LV};
    do_flush(ok);
    tests_run++;
    if (!ok || q_data.size() != 16) begin
      tests_failed++;
      $display("FAIL renorm_flush_count: got %0d required 16", q_data.size());
    end
    for (int i = 0; i < 16 && i < q_data.size(); i++) begin
      tests_run++;
      if ({q_last[i], q_lane[i], q_data[i]} !== exp_word(st, i)) begin
        tests_failed++;
        $display("FAIL renorm_flush_word%0d: got %h required %h", i, {q_last[i], q_lane[i], q_data[i]}, exp_word(st, i));
      end
    end
  endtask

  task automatic test_back_to_back();
    bit  ok, all_ok;
    int  lat;
    st_t st;
    clear_q();
    all_ok = 1'b1;
    for (int b = 0; b < 5; b++) begin
      encode(11'd512, 10'd0, lat, ok);
      all_ok &= ok;
    end
    tests_run++;
    if (!all_ok || q_data.size() != 0) begin
      tests_failed++;
      $display("FAIL b2b_no_output: got %0d words (ok=%0d) required 0", q_data.size(), all_ok);
    end
    st = '{32'h0400_0000, 32'h0200_0000, 32'h0200_0000, 32'h0200_0000};
    do_flush(ok);
    tests_run++;
    if (!ok || q_data.size() != 16) begin
      tests_failed++;
      $display("FAIL b2b_flush_count: got %0d required 16", q_data.size());
    end
    for (int i = 0; i < 16 && i < q_data.size(); i++) begin
      tests_run++;
      if ({q_last[i], q_lane[i], q_data[i]} !== exp_word(st, i)) begin
        tests_failed++;
        $display("FAIL b2b_flush_word%0d: got %h required %h", i, {q_last[i], q_lane[i], q_data[i]}, exp_word(st, i));
      end
    end
  endtask

  task automatic test_stall();
    bit   ok, ok2;
    int   lat, h, r, bad;
    st_t  st;
    logic [7:0] lanes_seen;
    clear_q();
    for (int b = 0; b < 4; b++) encode(11'd1, 10'd5, lat, ok);
    lanes_seen = 8'h00;
    for (int i = 0; i < 4 && i < q_lane.size(); i++) lanes_seen[2*i +: 2] = q_lane[i];
    tests_run++;
    if (q_data.size() != 4 || lanes_seen !== 8'b11_10_01_00) begin
      tests_failed++;
      $display("FAIL stall_prefill_lanes: got %0d words lanes %b required 4 words 11100100", q_data.size(), lanes_seen);
    end
    clear_q();
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    send_beat(11'd1, 10'd5, 1'b0, h, ok);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h05 || bus.out_lane !== 2'd0 || bus.out_last !== 1'b0)
        bad++;
    end
    tests_run++;
    if (!ok || bad != 0 || q_data.size() != 0) begin
      tests_failed++;
      $display("FAIL stall_hold: got %0d unstable cycles, %0d words required 0 and 0", bad, q_data.size());
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    wait_ready(r, ok2);
    tests_run++;
    if (!ok2 || q_data.size() != 1 || {q_last[0], q_lane[0], q_data[0]} !== 11'h005) begin
      tests_failed++;
      $display("FAIL stall_release: got %0d words (ok=%0d) required 1 word 005", q_data.size(), ok2);
    end
    st = '{32'h1000_0005, 32'h0400_0005, 32'h0400_0005, 32'h0400_0005};
    do_flush(ok);
    tests_run++;
    if (!ok || q_data.size() != 16) begin
      tests_failed++;
      $display("FAIL stall_flush_count: got %0d required 16", q_data.size());
    end
    for (int i = 0; i < 16 && i < q_data.size(); i++) begin
      tests_run++;
      if ({q_last[i], q_lane[i], q_data[i]} !== exp_word(st, i)) begin
        tests_failed++;
        $display("FAIL stall_flush_word%0d: got %h required %h", i, {q_last[i], q_lane[i], q_data[i]}, exp_word(st, i));
      end
    end
  endtask

  task automatic test_reset_mid_div();
    bit  ok;
    int  h;
    st_t st;
    send_beat(11'd512, 10'd0, 1'b0, h, ok);
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (!ok || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL middiv_reset: got valid=%b ready=%b required 0 0", bus.out_valid, bus.in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    st = '{LV, LV, LV, LV};
    do_flush(ok);
    tests_run++;
    if (!ok || q_data.size() != 16) begin
      tests_failed++;
      $display("FAIL middiv_flush_count: got %0d required 16", q_data.size());
    end
    for (int i = 0; i < 16 && i < q_data.size(); i++) begin
      tests_run++;
      if ({q_last[i], q_lane[i], q_data[i]} !== exp_word(st, i)) begin
        tests_failed++;
        $display("FAIL middiv_flush_word%0d: got %h required %h", i, {q_last[i], q_lane[i], q_data[i]}, exp_word(st, i));
      end
    end
  endtask

  task automatic test_err();
`ifdef RANS_ERR_CHECK_EN
    bit  ok;
    int  lat;
    st_t st;
    clear_q();
    encode(11'd0, 10'd0, lat, ok);
    tests_run++;
    if (!ok || lat != 1 || bus.err !== 1'b1 || q_data.size() != 0) begin
      tests_failed++;
      $display("FAIL err_f0: got lat=%0d err=%b words=%0d required 1 1 0", lat, bus.err, q_data.size());
    end
    encode(11'd512, 10'd0, lat, ok);
    st = '{32'h0200_0000, LV, LV, LV};
    do_flush(ok);
    tests_run++;
    if (!ok || q_data.size() != 16 || bus.err !== 1'b1) begin
      tests_failed++;
      $display("FAIL err_flush_count: got %0d words err=%b required 16 1", q_data.size(), bus.err);
    end
    for (int i = 0; i < 16 && i < q_data.size(); i++) begin
      tests_run++;
      if ({q_last[i], q_lane[i], q_data[i]} !== exp_word(st, i)) begin
        tests_failed++;
        $display("FAIL err_flush_word%0d: got %h required %h", i, {q_last[i], q_lane[i], q_data[i]}, exp_word(st, i));
      end
    end
`else
    tests_run++;
    if (bus.err !== 1'b0) begin
      tests_failed++;
      $display("FAIL err_tied_low: got %b required 0", bus.err);
    end
`endif
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_freq = '0;
    bus.in_cum_freq = '0;
    bus.in_flush = 1'b0;
    bus.out_ready = 1'b1;
    test_reset();
    test_flush_after_reset();
    test_single_symbol();
    test_renorm();
    test_back_to_back();
    test_stall();
    test_reset_mid_div();
    test_err();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
